// File: rtl/sim_run_controller_if.sv
// Handshake bundle between host/start logic, the run controller and the
// rule-update datapath. The master side is the host/datapath that drives
// commands and rule status; the slave side is the run controller.
interface sim_run_controller_if #(
    parameter int LOG_ITER = 16,
    parameter int STEADY_W = 4
);
    logic                start;
    logic                abort;
    logic                mode;
    logic [LOG_ITER-1:0] max_iter;
    logic [STEADY_W-1:0] steady_need;
    logic                valid_rule;
    logic                steady;
    logic                en_rng;
    logic                ld_next_state;
    logic                ld_updated;
    logic                ld_last_state;
    logic                clr_updated;
    logic                steady_state;
    logic                busy;
    logic                done;
    logic [LOG_ITER-1:0] iteration_number;

    modport master (
        output start, abort, mode, max_iter, steady_need, valid_rule, steady,
        input  en_rng, ld_next_state, ld_updated, ld_last_state, clr_updated,
        input  steady_state, busy, done, iteration_number
    );

    modport slave (
        input  start, abort, mode, max_iter, steady_need, valid_rule, steady,
        output en_rng, ld_next_state, ld_updated, ld_last_state, clr_updated,
        output steady_state, busy, done, iteration_number
    );
endinterface

// File: rtl/sim_run_controller.sv
// Run controller for the rule-update simulation datapath. Sequences one run
// (clear, iterate rules, stop) in random-asynchronous or round-based mode,
// with an iteration limit, consecutive-steady detection, abort and restart.
// Strobes are combinational from state, registered counters and valid_rule;
// every other output is registered.
module sim_run_controller #(
    parameter int LOG_ITER  = 16,
    parameter int NUM_RULES = 32,
    parameter int RULE_W    = 6,
    parameter int STEADY_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sim_run_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SIM   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [RULE_W-1:0]   LAST_RULE = RULE_W'(NUM_RULES - 1);
    localparam logic [RULE_W-1:0]   RULE_ONE  = RULE_W'(1);
    localparam logic [RULE_W-1:0]   RULE_ZERO = RULE_W'(0);
    localparam logic [LOG_ITER-1:0] ITER_ONE  = LOG_ITER'(1);
    localparam logic [LOG_ITER-1:0] ITER_ZERO = LOG_ITER'(0);
    localparam logic [STEADY_W-1:0] STDY_ONE  = STEADY_W'(1);
    localparam logic [STEADY_W-1:0] STDY_ZERO = STEADY_W'(0);

    state_t                state_r;
    state_t                state_next_s;

    logic                  mode_r;
    logic [LOG_ITER-1:0]   max_iter_r;
    logic [STEADY_W-1:0]   steady_need_r;
    logic [LOG_ITER-1:0]   iter_r;
    logic [RULE_W-1:0]     rule_r;
    logic [STEADY_W-1:0]   steady_cnt_r;
    logic                  steady_state_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  in_sim_s;
    logic                  round_end_s;
    logic                  eval_s;
    logic [STEADY_W-1:0]   steady_inc_s;
    logic [STEADY_W-1:0]   need_eff_s;
    logic                  steady_hit_s;
    logic                  limit_hit_s;
    logic                  start_ok_s;

    logic                  en_rng_s;
    logic                  ld_next_state_s;
    logic                  ld_updated_s;
    logic                  ld_last_state_s;
    logic                  clr_updated_s;

    // Saturating increment for the iteration counter.
    function automatic logic [LOG_ITER-1:0] sat_inc_iter(input logic [LOG_ITER-1:0] v);
        return (&v) ? v : (v + ITER_ONE);
    endfunction

    // Saturating increment for the steady-round counter.
    function automatic logic [STEADY_W-1:0] sat_inc_steady(input logic [STEADY_W-1:0] v);
        return (&v) ? v : (v + STDY_ONE);
    endfunction

    // Decode round end, steady evaluation, steady threshold and iteration limit.
    always_comb begin
        in_sim_s     = (state_r == ST_SIM);
        round_end_s  = in_sim_s && mode_r && bus.valid_rule && (rule_r == LAST_RULE);
        if (mode_r) begin
            eval_s = round_end_s;
        end else begin
            eval_s = in_sim_s && bus.valid_rule;
        end
        steady_inc_s = sat_inc_steady(steady_cnt_r);
        need_eff_s   = (steady_need_r == STDY_ZERO) ? STDY_ONE : steady_need_r;
        steady_hit_s = eval_s && bus.steady && (steady_inc_s >= need_eff_s);
        limit_hit_s  = in_sim_s && bus.valid_rule && (max_iter_r != ITER_ZERO)
                       && (iter_r == (max_iter_r - ITER_ONE));
        start_ok_s   = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    end

    // Next-state selection and datapath strobes.
    always_comb begin
        state_next_s    = state_r;
        en_rng_s        = 1'b0;
        ld_next_state_s = 1'b0;
        ld_updated_s    = 1'b0;
        ld_last_state_s = 1'b0;
        clr_updated_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clr_updated_s = 1'b1;
                if (bus.abort) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SIM;
                end
            end
            ST_SIM: begin
                en_rng_s     = 1'b1;
                ld_updated_s = bus.valid_rule;
                if (mode_r) begin
                    // Round-based: commit the whole round at once on its last rule.
                    ld_next_state_s = round_end_s;
                    ld_last_state_s = round_end_s;
                    clr_updated_s   = round_end_s;
                end else begin
                    ld_next_state_s = bus.valid_rule;
                    ld_last_state_s = bus.valid_rule;
                    clr_updated_s   = 1'b0;
                end
                if (bus.abort || steady_hit_s || limit_hit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SIM;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Run configuration capture and run counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r         <= 1'b0;
            max_iter_r     <= ITER_ZERO;
            steady_need_r  <= STDY_ZERO;
            iter_r         <= ITER_ZERO;
            rule_r         <= RULE_ZERO;
            steady_cnt_r   <= STDY_ZERO;
            steady_state_r <= 1'b0;
        end else if (start_ok_s) begin
            mode_r         <= bus.mode;
            max_iter_r     <= bus.max_iter;
            steady_need_r  <= bus.steady_need;
            iter_r         <= ITER_ZERO;
            rule_r         <= RULE_ZERO;
            steady_cnt_r   <= STDY_ZERO;
            steady_state_r <= 1'b0;
        end else if (in_sim_s && !bus.abort) begin
            if (bus.valid_rule) begin
                iter_r <= sat_inc_iter(iter_r);
                if (mode_r) begin
                    rule_r <= (rule_r == LAST_RULE) ? RULE_ZERO : (rule_r + RULE_ONE);
                end
            end
            if (eval_s) begin
                steady_cnt_r <= bus.steady ? steady_inc_s : STDY_ZERO;
            end
            if (steady_hit_s) begin
                steady_state_r <= 1'b1;
            end
        end
    end

    // Registered run status, taken from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_CLEAR) || (state_next_s == ST_SIM);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign bus.en_rng           = en_rng_s;
    assign bus.ld_next_state    = ld_next_state_s;
    assign bus.ld_updated       = ld_updated_s;
    assign bus.ld_last_state    = ld_last_state_s;
    assign bus.clr_updated      = clr_updated_s;
    assign bus.steady_state     = steady_state_r;
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
    assign bus.iteration_number = iter_r;

endmodule

// File: tb/tb_sim_run_controller.sv
// Self-checking bench for sim_run_controller: a hand-written vector table,
// directed multi-cycle sequences and a randomized run against a run-level
// reference model.
module tb_sim_run_controller;

    localparam int NR = 4;

    logic clk;
    logic rst;

    sim_run_controller_if #(.LOG_ITER(16), .STEADY_W(4)) bus ();

    sim_run_controller #(
        .LOG_ITER(16), .NUM_RULES(NR), .RULE_W(2), .STEADY_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Run configuration presented on the inputs each cycle
    logic        cfg_mode;
    logic [15:0] cfg_max;
    logic [3:0]  cfg_need;

    // Reference model: run phase plus run-level tallies
    localparam int P_IDLE = 0, P_CLEAR = 1, P_SIM = 2, P_DONE = 3;
    int m_phase;
    int m_mode;
    int m_max;
    int m_need;
    int m_cnt;     // valid rules accepted this run
    int m_run;     // consecutive steady evaluations
    bit m_ss;

    logic [4:0] last_strb;

    typedef struct {
        logic        st;
        logic        vr;
        logic [4:0]  strb;
        logic        busy;
        logic        done;
        logic [15:0] iter;
    } vec_t;
    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] model_strobes(input logic vr);
        logic [4:0] s;
        s = 5'b00000;
        if (m_phase == P_CLEAR) begin
            s = 5'b00001;
        end else if (m_phase == P_SIM) begin
            s[4] = 1'b1;
            s[2] = vr;
            if (m_mode == 0) begin
                s[3] = vr;
                s[1] = vr;
            end else if (vr && ((m_cnt + 1) % NR == 0)) begin
                s[3] = 1'b1;
                s[1] = 1'b1;
                s[0] = 1'b1;
            end
        end
        return s;
    endfunction

    task automatic model_edge(input logic r, input logic st, input logic ab,
                              input logic vr, input logic sd);
        bit fin;
        bit ev;
        fin = 1'b0;
        ev  = 1'b0;
        if (r) begin
            m_phase = P_IDLE; m_cnt = 0; m_run = 0; m_ss = 1'b0;
        end else if (m_phase == P_IDLE || m_phase == P_DONE) begin
            if (st) begin
                m_phase = P_CLEAR;
                m_mode  = int'(cfg_mode);
                m_max   = int'(cfg_max);
                m_need  = (cfg_need == 4'd0) ? 1 : int'(cfg_need);
                m_cnt = 0; m_run = 0; m_ss = 1'b0;
            end
        end else if (m_phase == P_CLEAR) begin
            m_phase = ab ? P_DONE : P_SIM;
        end else begin
            if (ab) begin
                m_phase = P_DONE;
            end else if (vr) begin
                ev = (m_mode == 0) || ((m_cnt + 1) % NR == 0);
                m_cnt++;
                if (m_max != 0 && m_cnt == m_max) fin = 1'b1;
                if (ev) begin
                    if (sd) begin
                        m_run++;
                        if (m_run >= m_need) begin
                            m_ss = 1'b1;
                            fin  = 1'b1;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
                if (fin) m_phase = P_DONE;
            end
        end
    endtask

    // One clock: drive after the falling edge, check strobes, clock, check status.
    task automatic step(input logic r, input logic st, input logic ab,
                        input logic vr, input logic sd);
        logic [4:0] exp_s;
        int         exp_iter;
        rst             = r;
        bus.start       = st;
        bus.abort       = ab;
        bus.valid_rule  = vr;
        bus.steady      = sd;
        bus.mode        = cfg_mode;
        bus.max_iter    = cfg_max;
        bus.steady_need = cfg_need;
        #1;
        exp_s     = model_strobes(vr);
        last_strb = {bus.en_rng, bus.ld_next_state, bus.ld_updated,
                     bus.ld_last_state, bus.clr_updated};
        check("strobes", {27'd0, last_strb}, {27'd0, exp_s});
        @(posedge clk);
        model_edge(r, st, ab, vr, sd);
        @(negedge clk);
        exp_iter = (m_cnt > 65535) ? 65535 : m_cnt;
        check("status", {29'd0, bus.busy, bus.done, bus.steady_state},
              {29'd0, (m_phase == P_CLEAR || m_phase == P_SIM), (m_phase == P_DONE), m_ss});
        check("iteration", {16'd0, bus.iteration_number}, exp_iter);
    endtask

    initial begin
        int vcount;
        int updcount;
        logic [11:0] round_mask;

        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.valid_rule = 1'b0; bus.steady = 1'b0;
        bus.mode = 1'b0; bus.max_iter = 16'd0; bus.steady_need = 4'd0;
        cfg_mode = 1'b0; cfg_max = 16'd0; cfg_need = 4'd0;
        m_phase = P_IDLE; m_mode = 0; m_max = 0; m_need = 1; m_cnt = 0; m_run = 0; m_ss = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_outputs", {13'd0, bus.busy, bus.done, bus.steady_state, bus.iteration_number}, 32'd0);

        // Table: mode 0, max_iter=5, steady_need=3, steady=0
        tbl[0] = '{st: 1'b1, vr: 1'b0, strb: 5'b00000, busy: 1'b1, done: 1'b0, iter: 16'd0};
        tbl[1] = '{st: 1'b0, vr: 1'b1, strb: 5'b00001, busy: 1'b1, done: 1'b0, iter: 16'd0};
        tbl[2] = '{st: 1'b0, vr: 1'b1, strb: 5'b11110, busy: 1'b1, done: 1'b0, iter: 16'd1};
        tbl[3] = '{st: 1'b0, vr: 1'b1, strb: 5'b11110, busy: 1'b1, done: 1'b0, iter: 16'd2};
        tbl[4] = '{st: 1'b0, vr: 1'b1, strb: 5'b11110, busy: 1'b1, done: 1'b0, iter: 16'd3};
        tbl[5] = '{st: 1'b0, vr: 1'b1, strb: 5'b11110, busy: 1'b1, done: 1'b0, iter: 16'd4};
        tbl[6] = '{st: 1'b0, vr: 1'b1, strb: 5'b11110, busy: 1'b0, done: 1'b1, iter: 16'd5};
        tbl[7] = '{st: 1'b0, vr: 1'b1, strb: 5'b00000, busy: 1'b0, done: 1'b1, iter: 16'd5};
        cfg_mode = 1'b0; cfg_max = 16'd5; cfg_need = 4'd3;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, tbl[i].st, 1'b0, tbl[i].vr, 1'b0);
            check("tbl_strobes", {27'd0, last_strb}, {27'd0, tbl[i].strb});
            check("tbl_status", {14'd0, bus.busy, bus.done, bus.iteration_number},
                  {14'd0, tbl[i].busy, tbl[i].done, tbl[i].iter});
        end
        check("tbl_steady_state", {31'd0, bus.steady_state}, 32'd0);

        // Mode 0, unlimited, steady pattern 1,1,0,1,1,1
        cfg_mode = 1'b0; cfg_max = 16'd0; cfg_need = 4'd3;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("steady_not_yet", {31'd0, bus.done}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("steady_run_end", {14'd0, bus.done, bus.steady_state, bus.iteration_number},
              {14'd0, 1'b1, 1'b1, 16'd6});

        // Mode 1, rounds of 4, 12 valid rules with gaps
        cfg_mode = 1'b1; cfg_max = 16'd0; cfg_need = 4'd3;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vcount = 0; updcount = 0; round_mask = 12'd0;
        for (int i = 0; i < 40 && vcount < 12; i++) begin
            if ((i % 3) != 1) begin
                step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                vcount++;
                if (last_strb[2]) updcount++;
                if (last_strb[3] && last_strb[1] && last_strb[0]) round_mask[vcount-1] = 1'b1;
            end else begin
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        check("round_strobes", {20'd0, round_mask}, {20'd0, 12'b1000_1000_1000});
        check("ld_updated_count", updcount, 32'd12);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Limit and steady threshold on the same rule
        cfg_mode = 1'b0; cfg_max = 16'd4; cfg_need = 4'd1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("limit_and_steady", {14'd0, bus.done, bus.steady_state, bus.iteration_number},
              {14'd0, 1'b1, 1'b1, 16'd4});

        // Abort at iteration 7, start while busy, restart in a new mode
        cfg_mode = 1'b0; cfg_max = 16'd0; cfg_need = 4'd15;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (7) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("start_ignored", {15'd0, bus.busy, bus.iteration_number}, {15'd0, 1'b1, 16'd7});
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("abort_hold", {14'd0, bus.done, bus.busy, bus.iteration_number},
              {14'd0, 1'b1, 1'b0, 16'd7});
        cfg_mode = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_clear", {14'd0, bus.busy, bus.done, bus.iteration_number},
              {14'd0, 1'b1, 1'b0, 16'd0});
        cfg_mode = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("new_mode_mid_round", {27'd0, last_strb}, {27'd0, 5'b10100});
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("new_mode_round_end", {27'd0, last_strb}, {27'd0, 5'b11111});

        // Reset for two cycles mid-run with valid rules
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("midrun_reset", {13'd0, bus.busy, bus.done, bus.steady_state, bus.iteration_number}, 32'd0);
        check("midrun_reset_strobes", {27'd0, bus.en_rng, bus.ld_next_state, bus.ld_updated,
              bus.ld_last_state, bus.clr_updated}, 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            cfg_mode = 1'($urandom_range(0, 1));
            cfg_max  = 16'($urandom_range(0, 20));
            cfg_need = 4'($urandom_range(0, 5));
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
